// File: rtl/uart_frame_tx_pkg.sv
// Shared types and constants for the UART frame transmitter.
// The optional checksum byte is controlled by UART_FRAME_TX_CHKSUM_EN.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  // Total bytes on the wire per frame: header + payload (+ checksum)
  function automatic int unsigned frame_bytes(input int unsigned data_bytes);
`ifdef UART_FRAME_TX_CHKSUM_EN
    return data_bytes + 2;
`else
    return data_bytes + 1;
`endif
  endfunction

endpackage

// File: rtl/uart_frame_tx_watchdog.sv
// Loadable cycle counter with clear/enable; expire is high on the cycle the
// count sits at LIMIT-1 while enabled. LIMIT=0 disables it (expire tied low).
module uart_tx_watchdog #(
  parameter int unsigned LIMIT = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic        expire
);

  generate
    if (LIMIT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      logic [31:0] count;

      // Cycle counter: clear has priority over load, load over increment
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (load) begin
          count <= load_value;
        end else if (enable) begin
          count <= count + 32'd1;
        end
      end

      assign expire = enable && (count == 32'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/uart_frame_tx.sv
// Framed byte-stream transmitter feeding a byte-level UART tx port.
// Frame: HEADER, payload bytes MSB-first, then an 8-bit payload checksum
// when UART_FRAME_TX_CHKSUM_EN is defined.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int unsigned DATA_BYTES     = 4,
  parameter logic [7:0]  HEADER         = DEFAULT_HEADER,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    word_valid_i,
  input  logic [8*DATA_BYTES-1:0] word_data_i,
  output logic                    word_ready_o,
  output logic                    tx_start_o,
  output logic [7:0]              tx_data_o,
  input  logic                    tx_done_i,
  output logic                    frame_done_o,
  output logic                    timeout_o,
  output logic                    busy_o
);

  localparam int unsigned FB = frame_bytes(DATA_BYTES);
  localparam int unsigned IW = $clog2(FB);
  localparam int unsigned WW = 8 * DATA_BYTES;

  state_t          state, state_next;
  logic [WW-1:0]   shreg;
  logic [IW-1:0]   idx;
  logic [7:0]      data_q;
  logic            done_q;
  logic            to_q;
  logic            accept, advance, finish, abort;
  logic            last, expire;

  assign last = (idx == IW'(FB - 1));

`ifdef UART_FRAME_TX_CHKSUM_EN
  logic [7:0] chksum;
  logic       next_is_sum;
  assign next_is_sum = (idx == IW'(FB - 2));
`endif

  uart_tx_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == SEND),
    .enable    (state == WAIT),
    .load      (1'b0),
    .load_value('0),
    .expire    (expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control decode; tx_done_i beats expire
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (word_valid_i) begin
          accept     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: state_next = WAIT;
      WAIT: begin
        if (tx_done_i) begin
          if (last) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = SEND;
          end
        end else if (expire) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: payload shift register, byte index, outgoing byte, pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg  <= '0;
      idx    <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
`ifdef UART_FRAME_TX_CHKSUM_EN
      chksum <= '0;
`endif
    end else begin
      done_q <= finish;
      to_q   <= abort;
      if (accept) begin
        shreg  <= word_data_i;
        idx    <= '0;
        data_q <= HEADER;
      end else if (advance) begin
        idx    <= idx + 1'b1;
        shreg  <= shreg << 8;
`ifdef UART_FRAME_TX_CHKSUM_EN
        data_q <= next_is_sum ? chksum : shreg[WW-1 -: 8];
`else
        data_q <= shreg[WW-1 -: 8];
`endif
      end else if (finish || abort) begin
        idx <= '0;
      end
`ifdef UART_FRAME_TX_CHKSUM_EN
      // The sum is complete before the advance that selects it, since the
      // last payload byte is added during its own SEND cycle.
      if (accept) begin
        chksum <= '0;
      end else if (state == SEND && idx != '0 && !last) begin
        chksum <= chksum + data_q;
      end
`endif
    end
  end

  assign word_ready_o = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign tx_start_o   = (state == SEND);
  assign tx_data_o    = data_q;
  assign frame_done_o = done_q;
  assign timeout_o    = to_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: per-cycle comparison against a frame-level model
// plus hand-computed byte sequences and latencies.
module tb_uart_frame_tx;

  localparam int unsigned DB = 4;
  localparam int unsigned TO = 100;
`ifdef UART_FRAME_TX_CHKSUM_EN
  localparam int NB     = DB + 2;
  localparam bit SUM_EN = 1'b1;
`else
  localparam int NB     = DB + 1;
  localparam bit SUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        word_valid_i;
  logic [31:0] word_data_i;
  logic        word_ready_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_done_i;
  logic        frame_done_o;
  logic        timeout_o;
  logic        busy_o;
  logic        resp_done;
  logic        idle_spur;

  assign tx_done_i = resp_done | idle_spur;

  always #10 clk = ~clk;

  uart_frame_tx #(
    .DATA_BYTES    (DB),
    .HEADER        (8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .word_valid_i(word_valid_i),
    .word_data_i (word_data_i),
    .word_ready_o(word_ready_o),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o),
    .tx_done_i   (tx_done_i),
    .frame_done_o(frame_done_o),
    .timeout_o   (timeout_o),
    .busy_o      (busy_o)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Frame-level model: a queue of bytes still to go, timed by the handshake rules
  logic [7:0] m_q[$];
  bit         m_on = 1'b0;
  bit         m_busy, m_wait;
  int         m_cnt;
  bit         e_start, e_done, e_to, e_dknown;
  logic [7:0] e_data;

  always @(posedge clk) begin
    logic [7:0] s;
    e_start = 1'b0;
    e_done  = 1'b0;
    e_to    = 1'b0;
    m_on    = 1'b1;
    if (!rst_n) begin
      m_busy = 1'b0; m_wait = 1'b0; m_q.delete();
      e_data = 8'h00; e_dknown = 1'b1;
    end else if (!m_busy) begin
      if (word_valid_i) begin
        s = 8'h00;
        m_q.delete();
        m_q.push_back(8'hA5);
        for (int i = DB - 1; i >= 0; i--) begin
          m_q.push_back(word_data_i[8*i +: 8]);
          s = s + word_data_i[8*i +: 8];
        end
        if (SUM_EN) m_q.push_back(s);
        m_busy = 1'b1; m_wait = 1'b0;
        e_start = 1'b1; e_data = m_q[0]; e_dknown = 1'b1;
      end
    end else if (!m_wait) begin
      m_wait = 1'b1;
      m_cnt  = 0;
    end else if (tx_done_i) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        e_done = 1'b1; m_busy = 1'b0; e_dknown = 1'b0;
      end else begin
        e_start = 1'b1; e_data = m_q[0]; m_wait = 1'b0;
      end
    end else if (m_cnt == int'(TO) - 1) begin
      e_to = 1'b1; m_busy = 1'b0; e_dknown = 1'b0; m_q.delete();
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("cycle_outputs", {word_ready_o, busy_o, tx_start_o, frame_done_o, timeout_o},
          {!m_busy, m_busy, e_start, e_done, e_to});
      if (e_dknown) chk("cycle_tx_data", tx_data_o, e_data);
    end
  end

  // UART stand-in: done pulse done_delay cycles after each start; logs starts
  int         done_delay = 3;
  bit         spur_send  = 1'b0;
  int         rcnt       = 0;
  int         last_done_cyc = 0;
  int         start_cyc[$];
  logic [7:0] started[$];

  initial resp_done = 1'b0;

  always @(negedge clk) begin
    resp_done = 1'b0;
    if (!rst_n) rcnt = 0;
    else if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        resp_done = 1'b1;
        last_done_cyc = cyc;
      end
    end
    if (tx_start_o) begin
      started.push_back(tx_data_o);
      start_cyc.push_back(cyc);
      if (done_delay > 0) rcnt = done_delay;
      if (spur_send) resp_done = 1'b1;
    end
  end

  task automatic send_word(input logic [31:0] w);
    started.delete();
    start_cyc.delete();
    word_valid_i = 1'b1;
    word_data_i  = w;
    @(negedge clk);
    word_valid_i = 1'b0;
    word_data_i  = ~w;
  endtask

  task automatic wait_end(output int c, output bit was_to);
    c = -1;
    was_to = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (frame_done_o || timeout_o) begin
        c = cyc;
        was_to = timeout_o;
        return;
      end
    end
    total_cnt++;
    $display("FAIL wait_end: no frame_done_o or timeout_o within 2000 cycles");
  endtask

  // exp holds up to 6 bytes, first byte in bits [47:40]; only NB are compared
  task automatic check_bytes(input string name, input logic [47:0] exp);
    chk({name, "_count"}, started.size(), NB);
    for (int i = 0; i < NB && i < started.size(); i++)
      chk({name, "_byte"}, started[i], exp[47-8*i -: 8]);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    bit was_to;
    int bad;
    bit hit;
    rst_n = 1'b0; word_valid_i = 1'b0; word_data_i = '0; idle_spur = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {word_ready_o, busy_o, tx_start_o, tx_data_o, frame_done_o, timeout_o},
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});

    // Basic frame, done 3 cycles after each start
    done_delay = 3;
    send_word(32'h12345678);
    wait_end(c, was_to);
    check_bytes("basic", 48'hA5_12_34_56_78_14);
    chk("basic_done_latency", c - last_done_cyc, 1);
    chk("basic_not_timeout", was_to, 1'b0);

    // Zero-latency done, then back-to-back word on the frame_done cycle
    repeat (2) @(negedge clk);
    done_delay = 1;
    send_word(32'hA1B2C3D4);
    wait_end(c, was_to);
    started.delete();
    start_cyc.delete();
    word_valid_i = 1'b1;
    word_data_i  = 32'hFFFFFFFF;
    @(negedge clk);
    word_valid_i = 1'b0;
    word_data_i  = 32'h0;
    begin
      int c2;
      wait_end(c2, was_to);
    end
    check_bytes("b2b", 48'hA5_FF_FF_FF_FF_FC);
    chk("b2b_header_cycle", (start_cyc.size() > 0) ? start_cyc[0] - c : -1, 2 - 1);
    bad = 0;
    for (int i = 0; i + 1 < start_cyc.size(); i++)
      if (start_cyc[i+1] - start_cyc[i] != 2) bad++;
    chk("fast_start_spacing", bad, 0);

    // Timeout: no done for the header
    repeat (2) @(negedge clk);
    done_delay = 0;
    send_word(32'hCAFEF00D);
    wait_end(c, was_to);
    chk("timeout_flag", was_to, 1'b1);
    chk("timeout_latency", (start_cyc.size() > 0) ? c - start_cyc[0] : -1, 101);
    chk("timeout_one_start", started.size(), 1);
    @(negedge clk);
    chk("timeout_idle", {word_ready_o, busy_o, frame_done_o, timeout_o}, 4'b1000);

    // Reset during the third byte, then a clean frame
    done_delay = 3;
    send_word(32'hDEADBEEF);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (started.size() >= 3) hit = 1'b1;
    end
    chk("reset_reached_byte3", hit, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midframe_reset_state", {word_ready_o, busy_o, tx_start_o, tx_data_o, frame_done_o, timeout_o},
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    repeat (4) @(negedge clk);
    done_delay = 2;
    send_word(32'h00000001);
    wait_end(c, was_to);
    check_bytes("after_reset", 48'hA5_00_00_00_01_01);

    // Spurious done in IDLE and SEND, valid toggling while busy
    idle_spur = 1'b1;
    @(negedge clk);
    idle_spur = 1'b0;
    @(negedge clk);
    done_delay = 3;
    spur_send  = 1'b1;
    started.delete();
    start_cyc.delete();
    word_valid_i = 1'b1;
    word_data_i  = 32'h0F1E2D3C;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      word_valid_i = ~word_valid_i;
      word_data_i  = 32'h11111111 * (i + 1);
      @(negedge clk);
    end
    word_valid_i = 1'b0;
    wait_end(c, was_to);
    spur_send = 1'b0;
    check_bytes("spurious", 48'hA5_0F_1E_2D_3C_96);
    idle_spur = 1'b1;
    @(negedge clk);
    idle_spur = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
